// File: rtl/simple_bus_pkg.sv
// Shared types for the simple_bus memory target: transaction modes, FSM states
// and small mode-decoding helpers.
package simple_bus_pkg;

   typedef enum logic [1:0] {
      SINGLE_READ  = 2'b00,
      SINGLE_WRITE = 2'b01,
      BURST_READ   = 2'b10,
      BURST_WRITE  = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      WAIT,
      BEAT
   } state_t;

   function automatic logic is_burst(mode_t m);
      return m[1];
   endfunction

   function automatic logic is_write(mode_t m);
      return m[0];
   endfunction

endpackage

// File: rtl/simple_bus_mem_array.sv
// DEPTH x DATA_WIDTH storage with one synchronous write port and one
// registered read port (read data appears the cycle after raddr).
module simple_bus_mem_array #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 256
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/simple_bus_mem_slave.sv
// simple_bus memory target: grant/start handshake, programmable wait states,
// fixed-length wrapping bursts and an out-of-range error response.
module simple_bus_mem_slave
   import simple_bus_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 16,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1,
   parameter int BURST_LEN   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   output logic                  gnt,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rdy,
   output logic                  err
);

   localparam int WCW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
   localparam int BCW = $clog2(BURST_LEN);
   localparam logic [WCW-1:0]        WAIT_LOAD  = WCW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
   localparam logic [BCW-1:0]        BURST_LOAD = BCW'(BURST_LEN - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT  = (ADDR_WIDTH + 1)'(DEPTH);

   state_t                state, state_n;
   mode_t                 mode_q, mode_n;
   logic [WCW-1:0]        wait_cnt, wait_n;
   logic [BCW-1:0]        beat_cnt, beat_n;
   logic [ADDR_WIDTH-1:0] cur_addr, addr_n;
   logic                  err_q, err_n;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [DATA_WIDTH-1:0] rdata_hold;
   logic                  mem_we;

   always_comb begin
      state_n = state;
      mode_n  = mode_q;
      wait_n  = wait_cnt;
      beat_n  = beat_cnt;
      addr_n  = cur_addr;
      err_n   = err_q;
      case (state)
         IDLE: begin
            if (req) state_n = GRANT;
         end
         GRANT: begin
            // start wins over a simultaneous req drop
            if (start) begin
               mode_n  = mode_t'(mode);
               addr_n  = addr;
               err_n   = ({1'b0, addr} >= DEPTH_EXT);
               beat_n  = is_burst(mode_t'(mode)) ? BURST_LOAD : '0;
               wait_n  = WAIT_LOAD;
               state_n = (WAIT_STATES > 0) ? WAIT : BEAT;
            end else if (!req) begin
               state_n = IDLE;
            end
         end
         WAIT: begin
            if (wait_cnt == '0) state_n = BEAT;
            else                wait_n  = wait_cnt - WCW'(1);
         end
         BEAT: begin
            if (beat_cnt == '0) begin
               state_n = IDLE;
            end else begin
               beat_n  = beat_cnt - BCW'(1);
               addr_n  = (cur_addr == LAST_ADDR) ? '0 : cur_addr + ADDR_WIDTH'(1);
               wait_n  = WAIT_LOAD;
               state_n = (WAIT_STATES > 0) ? WAIT : BEAT;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state so they line up
   // with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         mode_q     <= SINGLE_READ;
         wait_cnt   <= '0;
         beat_cnt   <= '0;
         cur_addr   <= '0;
         err_q      <= 1'b0;
         gnt        <= 1'b0;
         rdy        <= 1'b0;
         err        <= 1'b0;
         rdata_hold <= '0;
      end else begin
         state      <= state_n;
         mode_q     <= mode_n;
         wait_cnt   <= wait_n;
         beat_cnt   <= beat_n;
         cur_addr   <= addr_n;
         err_q      <= err_n;
         gnt        <= (state_n != IDLE);
         rdy        <= (state_n == BEAT);
         err        <= (state_n == BEAT) && err_n;
         rdata_hold <= rdata;
      end
   end

   assign mem_we = (state == BEAT) && is_write(mode_q) && !err_q;

   // Read data tracks the memory only on read beats and holds otherwise.
   assign rdata = (rdy && !is_write(mode_q)) ? (err_q ? '0 : mem_rdata) : rdata_hold;

   simple_bus_mem_array #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
   ) u_mem (
      .clk  (clk),
      .we   (mem_we),
      .waddr(cur_addr),
      .wdata(wdata),
      .raddr(addr_n),
      .rdata(mem_rdata)
   );

endmodule

// File: tb/tb_simple_bus_mem_slave.sv
// Scoreboard bench for simple_bus_mem_slave across three configurations:
// nominal (256/1 wait), non-power-of-two depth (200) and zero wait states.
module tb_simple_bus_mem_slave;

   localparam logic [1:0] M_SR = 2'b00;
   localparam logic [1:0] M_SW = 2'b01;
   localparam logic [1:0] M_BR = 2'b10;
   localparam logic [1:0] M_BW = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_v   [3];
   logic        start_v [3];
   logic [1:0]  mode_v  [3];
   logic [7:0]  addr_v  [3];
   logic [15:0] wdata_v [3];
   logic        gnt_v   [3];
   logic        rdy_v   [3];
   logic        err_v   [3];
   logic [15:0] rdata_v [3];

   typedef struct {
      logic [15:0] data;
      logic        err;
      logic        is_read;
      logic [7:0]  addr;
   } exp_t;

   exp_t        sb [$];
   logic [15:0] model [3][256];
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   simple_bus_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(256), .WAIT_STATES(1), .BURST_LEN(4)) dut_main (
      .clk(clk), .rst(rst), .req(req_v[0]), .gnt(gnt_v[0]), .start(start_v[0]), .mode(mode_v[0]),
      .addr(addr_v[0]), .wdata(wdata_v[0]), .rdata(rdata_v[0]), .rdy(rdy_v[0]), .err(err_v[0]));

   simple_bus_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(200), .WAIT_STATES(1), .BURST_LEN(4)) dut_err (
      .clk(clk), .rst(rst), .req(req_v[1]), .gnt(gnt_v[1]), .start(start_v[1]), .mode(mode_v[1]),
      .addr(addr_v[1]), .wdata(wdata_v[1]), .rdata(rdata_v[1]), .rdy(rdy_v[1]), .err(err_v[1]));

   simple_bus_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(256), .WAIT_STATES(0), .BURST_LEN(4)) dut_fast (
      .clk(clk), .rst(rst), .req(req_v[2]), .gnt(gnt_v[2]), .start(start_v[2]), .mode(mode_v[2]),
      .addr(addr_v[2]), .wdata(wdata_v[2]), .rdata(rdata_v[2]), .rdy(rdy_v[2]), .err(err_v[2]));

   function automatic int depth_of(input int d);
      return (d == 1) ? 200 : 256;
   endfunction

   function automatic int ws_of(input int d);
      return (d == 2) ? 0 : 1;
   endfunction

   task automatic check_idle_outputs(input int d, input string name);
      vectors++;
      if (gnt_v[d] !== 1'b0 || rdy_v[d] !== 1'b0 || err_v[d] !== 1'b0 || rdata_v[d] !== 16'h0) begin
         miscompares++;
         $display("[TB] FAIL %s dut%0d: gnt=%b rdy=%b err=%b rdata=%h, required all 0", name, d,
                  gnt_v[d], rdy_v[d], err_v[d], rdata_v[d]);
      end
   endtask

   // One complete transaction; abort_after>0 asserts rst after that many beats.
   task automatic do_txn(input int d, input logic [1:0] m, input logic [7:0] a,
                         input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] w2, input logic [15:0] w3, input int abort_after);
      logic [15:0] wd [4];
      int          nb;
      int          cnt;
      int          depth;
      logic [7:0]  ca;
      logic        e;
      bit          ok;
      exp_t        x;
      wd[0] = w0; wd[1] = w1; wd[2] = w2; wd[3] = w3;
      nb    = m[1] ? 4 : 1;
      depth = depth_of(d);
      @(posedge clk); #1;
      req_v[d] = 1'b1;
      cnt = 0; ok = 0;
      while (!ok && cnt < 10) begin
         @(negedge clk); cnt++;
         if (gnt_v[d] === 1'b1) ok = 1;
      end
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("[TB] FAIL grant_wait dut%0d: gnt=%b after %0d cycles, required 1", d, gnt_v[d], cnt);
         req_v[d] = 1'b0;
         return;
      end
      start_v[d] = 1'b1; mode_v[d] = m; addr_v[d] = a; wdata_v[d] = wd[0];
      e  = (int'(a) >= depth);
      ca = a;
      for (int i = 0; i < nb; i++) begin
         x.addr    = ca;
         x.err     = e;
         x.is_read = !m[0];
         x.data    = m[0] ? wd[i] : (e ? 16'h0 : model[d][ca]);
         sb.push_back(x);
         ca = (int'(ca) == depth - 1) ? 8'h00 : ca + 8'h01;
      end
      @(posedge clk); #1;
      start_v[d] = 1'b0;
      for (int i = 0; i < nb; i++) begin
         cnt = 0; ok = 0;
         while (!ok && cnt < 20) begin
            @(negedge clk); cnt++;
            if (rdy_v[d] === 1'b1) ok = 1;
         end
         vectors++;
         if (!ok) begin
            miscompares++;
            $display("[TB] FAIL beat_timeout dut%0d beat%0d: rdy=%b after %0d cycles, required 1", d, i, rdy_v[d], cnt);
            sb.delete();
            req_v[d] = 1'b0;
            return;
         end
         vectors++;
         if (cnt != ws_of(d) + 1) begin
            miscompares++;
            $display("[TB] FAIL latency dut%0d beat%0d: %0d cycles, required %0d", d, i, cnt, ws_of(d) + 1);
         end
         x = sb.pop_front();
         vectors++;
         if (err_v[d] !== x.err) begin
            miscompares++;
            $display("[TB] FAIL err_flag dut%0d addr %h: err=%b, required %b", d, x.addr, err_v[d], x.err);
         end
         if (x.is_read) begin
            vectors++;
            if (rdata_v[d] !== x.data) begin
               miscompares++;
               $display("[TB] FAIL read_data dut%0d addr %h: rdata=%h, required %h", d, x.addr, rdata_v[d], x.data);
            end
         end else if (!x.err) begin
            model[d][x.addr] = x.data;
         end
         if (abort_after != 0 && i + 1 == abort_after) begin
            @(posedge clk); #1;
            rst = 1'b1; req_v[d] = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            check_idle_outputs(d, "abort_reset");
            sb.delete();
            return;
         end
         if (i + 1 < nb) begin
            @(posedge clk); #1;
            wdata_v[d] = wd[i + 1];
         end
      end
      @(posedge clk); #1;
      req_v[d] = 1'b0;
      @(negedge clk);
      vectors++;
      if (gnt_v[d] !== 1'b0 || rdy_v[d] !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL gnt_release dut%0d: gnt=%b rdy=%b, required 0/0", d, gnt_v[d], rdy_v[d]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int d = 0; d < 3; d++) req_v[d] = 1'b1;
      repeat (2) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) check_idle_outputs(d, "reset_state");
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         vectors++;
         if (gnt_v[d] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL gnt_after_reset dut%0d: gnt=%b, required 1", d, gnt_v[d]);
         end
         req_v[d] = 1'b0;
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) check_idle_outputs(d, "gnt_withdrawn");
   endtask

   task automatic test_single_rw();
      do_txn(0, M_SW, 8'h10, 16'hBEEF, 16'h0, 16'h0, 16'h0, 0);
      do_txn(0, M_SR, 8'h10, 16'h0, 16'h0, 16'h0, 16'h0, 0);
   endtask

   task automatic test_burst_wrap();
      do_txn(0, M_BW, 8'hFE, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 0);
      do_txn(0, M_BR, 8'hFE, 16'h0, 16'h0, 16'h0, 16'h0, 0);
   endtask

   task automatic test_stray_start();
      @(posedge clk); #1;
      start_v[0] = 1'b1; mode_v[0] = M_SW; addr_v[0] = 8'h10; wdata_v[0] = 16'h0BAD;
      repeat (3) begin
         @(negedge clk);
         vectors++;
         if (gnt_v[0] !== 1'b0 || rdy_v[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stray_start: gnt=%b rdy=%b, required 0/0", gnt_v[0], rdy_v[0]);
         end
      end
      start_v[0] = 1'b0;
      @(posedge clk); #1;
      req_v[0] = 1'b1;
      @(posedge clk); #1;
      req_v[0] = 1'b0;
      @(negedge clk);
      vectors++;
      if (gnt_v[0] !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL req_pulse_gnt: gnt=%b, required 1", gnt_v[0]);
      end
      repeat (2) begin
         @(negedge clk);
         vectors++;
         if (gnt_v[0] !== 1'b0 || rdy_v[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL req_pulse_drop: gnt=%b rdy=%b, required 0/0", gnt_v[0], rdy_v[0]);
         end
      end
      do_txn(0, M_SR, 8'h10, 16'h0, 16'h0, 16'h0, 16'h0, 0);
   endtask

   task automatic test_error();
      do_txn(1, M_SW, 8'h00, 16'h5A5A, 16'h0, 16'h0, 16'h0, 0);
      do_txn(1, M_SW, 8'hC8, 16'hDEAD, 16'h0, 16'h0, 16'h0, 0);
      do_txn(1, M_SR, 8'hC8, 16'h0, 16'h0, 16'h0, 16'h0, 0);
      do_txn(1, M_SR, 8'h00, 16'h0, 16'h0, 16'h0, 16'h0, 0);
      do_txn(1, M_BR, 8'hFF, 16'h0, 16'h0, 16'h0, 16'h0, 0);
      do_txn(1, M_BW, 8'hC6, 16'hA1A1, 16'hA2A2, 16'hA3A3, 16'hA4A4, 0);
      do_txn(1, M_BR, 8'hC6, 16'h0, 16'h0, 16'h0, 16'h0, 0);
   endtask

   task automatic test_reset_mid_burst();
      do_txn(0, M_BW, 8'h20, 16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3, 0);
      do_txn(0, M_SR, 8'h20, 16'h0, 16'h0, 16'h0, 16'h0, 0);
      do_txn(0, M_BW, 8'h20, 16'hC0C0, 16'hC1C1, 16'hC2C2, 16'hC3C3, 2);
      do_txn(0, M_BR, 8'h20, 16'h0, 16'h0, 16'h0, 16'h0, 0);
   endtask

   task automatic test_back_to_back();
      do_txn(2, M_BW, 8'h40, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 0);
      do_txn(2, M_BR, 8'h40, 16'h0, 16'h0, 16'h0, 16'h0, 0);
      do_txn(2, M_BW, 8'hFE, 16'h7777, 16'h8888, 16'h9999, 16'hAAAA, 0);
      do_txn(2, M_BR, 8'hFE, 16'h0, 16'h0, 16'h0, 16'h0, 0);
   endtask

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         req_v[d] = 1'b0; start_v[d] = 1'b0; mode_v[d] = 2'b00;
         addr_v[d] = 8'h00; wdata_v[d] = 16'h0;
      end
      test_reset();
      test_single_rw();
      test_burst_wrap();
      test_stray_start();
      test_error();
      test_reset_mid_burst();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
